// File: rtl/wisc_pkg.sv
// Shared WISC-SP22 pipeline constants, the halt sequencer state encoding and a saturating-count helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wisc_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 3;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DUMP   = 2'b01,
    HALTED = 2'b10
  } halt_state_t;

  // Increment that sticks at all-ones instead of wrapping back to zero
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ex_mem_latch_if.sv
// EX->MEM bundle: execute-stage fields, hazard controls and memory-stage outputs of the EX/MEM latch.
// Latency: n/a (wiring only); optional counters appear when EX_MEM_STATS_EN is defined.
// Backpressure: Stall/Flush from the hazard unit travel in this bundle alongside the data.
interface ex_mem_latch_if;
  import wisc_pkg::*;

  // hazard controls
  logic              Stall;
  logic              Flush;
  // execute stage side
  logic              in_Valid;
  logic [DATA_W-1:0] in_XOut;
  logic [DATA_W-1:0] in_WriteData;
  logic [DATA_W-1:0] in_PCInc;
  logic              in_MemRead;
  logic              in_MemWrite;
  logic              in_RegWrite;
  logic              in_MemToReg;
  logic              in_Link;
  logic [REG_W-1:0]  in_WriteReg;
  logic              in_Halt;
  // memory stage side
  logic              out_Valid;
  logic [DATA_W-1:0] XOut;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] out_PCInc;
  logic              MemRead;
  logic              MemWrite;
  logic              out_RegWrite;
  logic              out_MemToReg;
  logic              out_Link;
  logic [REG_W-1:0]  out_WriteReg;
  logic              createdump;
  logic              halted;
  logic              err;
`ifdef EX_MEM_STATS_EN
  logic [15:0]       stall_cnt;
  logic [15:0]       bubble_cnt;
`endif

  // Pipeline side that feeds the latch and consumes its outputs
  modport master (
    output Stall, Flush, in_Valid, in_XOut, in_WriteData, in_PCInc,
           in_MemRead, in_MemWrite, in_RegWrite, in_MemToReg, in_Link,
           in_WriteReg, in_Halt,
`ifdef EX_MEM_STATS_EN
    input  stall_cnt, bubble_cnt,
`endif
    input  out_Valid, XOut, WriteData, out_PCInc, MemRead, MemWrite,
           out_RegWrite, out_MemToReg, out_Link, out_WriteReg,
           createdump, halted, err
  );

  // The latch itself
  modport slave (
    input  Stall, Flush, in_Valid, in_XOut, in_WriteData, in_PCInc,
           in_MemRead, in_MemWrite, in_RegWrite, in_MemToReg, in_Link,
           in_WriteReg, in_Halt,
`ifdef EX_MEM_STATS_EN
    output stall_cnt, bubble_cnt,
`endif
    output out_Valid, XOut, WriteData, out_PCInc, MemRead, MemWrite,
           out_RegWrite, out_MemToReg, out_Link, out_WriteReg,
           createdump, halted, err
  );

endinterface

// File: rtl/ex_mem_latch_pipe_reg.sv
// Generic W-bit pipeline register with rst > flush > hold > load priority.
// Latency: 1 cycle from d to q on a load.
// Backpressure: hold keeps q unchanged; flush zeroes q (bubble).
module pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         hold,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Reset and flush both clear; otherwise capture unless held
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline latch with stall/flush, a HALT -> createdump -> frozen sequencer and a sticky error flag.
// Latency: 1 cycle input to output; EX_MEM_STATS_EN adds stall/bubble counters.
// Backpressure: Stall holds every field, Flush inserts a bubble (Flush wins); both ignored once HALT is captured.
module ex_mem_latch
  import wisc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  ex_mem_latch_if.slave   bus
);

  halt_state_t state;
  logic        createdump_q;
  logic        halted_q;
  logic        err_q;

  logic in_run;
  logic load_en;
  logic reg_hold;
  logic reg_flush;

  // Only RUN accepts new instructions; DUMP and HALTED freeze the fields
  assign in_run    = (state == RUN);
  assign reg_flush = in_run & bus.Flush;
  assign reg_hold  = ~in_run | bus.Stall;
  assign load_en   = in_run & ~bus.Flush & ~bus.Stall;

  // ---------------------------------------------------------------
  // Field registers
  // ---------------------------------------------------------------
  localparam int CTRL_W = 6 + REG_W;

  logic [CTRL_W-1:0]   ctrl_d, ctrl_q;
  logic [2*DATA_W-1:0] data_d, data_q;
  logic [DATA_W-1:0]   pc_q;

  logic             valid_q;
  logic             mr_q, mw_q, rw_q, m2r_q, lk_q;
  logic [REG_W-1:0] wr_q;

  assign ctrl_d = {bus.in_Valid, bus.in_MemRead, bus.in_MemWrite,
                   bus.in_RegWrite, bus.in_MemToReg, bus.in_Link,
                   bus.in_WriteReg};
  assign data_d = {bus.in_XOut, bus.in_WriteData};

  pipe_reg #(.W(CTRL_W)) u_ctrl (
    .clk   (clk),
    .rst   (rst),
    .flush (reg_flush),
    .hold  (reg_hold),
    .d     (ctrl_d),
    .q     (ctrl_q)
  );

  pipe_reg #(.W(2*DATA_W)) u_data (
    .clk   (clk),
    .rst   (rst),
    .flush (reg_flush),
    .hold  (reg_hold),
    .d     (data_d),
    .q     (data_q)
  );

  pipe_reg #(.W(DATA_W)) u_pc (
    .clk   (clk),
    .rst   (rst),
    .flush (reg_flush),
    .hold  (reg_hold),
    .d     (bus.in_PCInc),
    .q     (pc_q)
  );

  assign {valid_q, mr_q, mw_q, rw_q, m2r_q, lk_q, wr_q} = ctrl_q;

  // ---------------------------------------------------------------
  // Halt sequencer: one createdump cycle, then frozen until rst
  // ---------------------------------------------------------------
  // Single-block FSM with registered createdump/halted flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      createdump_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (load_en && bus.in_Valid && bus.in_Halt) begin
            state        <= DUMP;
            createdump_q <= 1'b1;
          end
        end
        DUMP: begin
          state        <= HALTED;
          createdump_q <= 1'b0;
          halted_q     <= 1'b1;
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state        <= RUN;
          createdump_q <= 1'b0;
          halted_q     <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Sticky error
  // ---------------------------------------------------------------
  logic err_x;
  logic err_now;

`ifndef SYNTHESIS
  assign err_x = $isunknown({bus.Stall, bus.Flush, bus.in_Valid,
                             bus.in_MemRead, bus.in_MemWrite, bus.in_RegWrite,
                             bus.in_MemToReg, bus.in_Link, bus.in_Halt,
                             bus.in_WriteReg,
                             ^bus.in_XOut, ^bus.in_WriteData});
`else
  assign err_x = 1'b0;
`endif

  // Conflicting load+store, or a word access on an odd address
  assign err_now = (bus.in_MemRead & bus.in_MemWrite)
                 | ((bus.in_MemRead | bus.in_MemWrite) & bus.in_XOut[0])
                 | err_x;

  // Set on an offending load; only rst clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (load_en && bus.in_Valid && err_now) begin
      err_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------
  // Outputs: every enable gated by the registered valid so a bubble is inert
  // ---------------------------------------------------------------
  logic enables_live;
  assign enables_live = valid_q & ~halted_q;

  assign bus.out_Valid    = valid_q;
  assign bus.XOut         = data_q[2*DATA_W-1:DATA_W];
  assign bus.WriteData    = data_q[DATA_W-1:0];
  assign bus.out_PCInc    = pc_q;
  assign bus.out_WriteReg = wr_q;
  assign bus.MemRead      = mr_q & valid_q & in_run;
  assign bus.MemWrite     = mw_q & valid_q & in_run;
  assign bus.out_RegWrite = rw_q  & enables_live;
  assign bus.out_MemToReg = m2r_q & enables_live;
  assign bus.out_Link     = lk_q  & enables_live;
  assign bus.createdump   = createdump_q & valid_q;
  assign bus.halted       = halted_q;
  assign bus.err          = err_q;

`ifdef EX_MEM_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] bubble_cnt_q;

  // Saturating hazard counters, live only while the pipe is running
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= 16'd0;
      bubble_cnt_q <= 16'd0;
    end else if (in_run) begin
      if (bus.Flush) begin
        bubble_cnt_q <= sat_inc16(bubble_cnt_q);
      end else if (bus.Stall) begin
        stall_cnt_q <= sat_inc16(stall_cnt_q);
      end
    end
  end

  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_latch.sv
// Randomized + directed bench for ex_mem_latch against an in-bench behavioural model.
// Latency: model predicts outputs one edge after inputs; compare runs on every falling edge.
// Backpressure: exercises Stall/Flush priority, halt sequencing and (optionally) the counters.
module tb_ex_mem_latch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_mem_latch_if bus();

  ex_mem_latch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = running, 1 = dumping (one cycle), 2 = frozen
  int          m_mode = 0;
  logic        m_valid, m_mr, m_mw, m_rw, m_m2r, m_lk, m_err;
  logic [15:0] m_xout, m_wd, m_pc;
  logic [2:0]  m_wr;
  logic [15:0] m_stall, m_bubble;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_err = 0;
      {m_valid, m_mr, m_mw, m_rw, m_m2r, m_lk} = '0;
      m_xout = 0; m_wd = 0; m_pc = 0; m_wr = 0;
      m_stall = 0; m_bubble = 0;
    end else if (m_mode == 1) begin
      m_mode = 2;
    end else if (m_mode == 0) begin
      if (bus.Flush) begin
        if (m_bubble != 16'hFFFF) m_bubble = m_bubble + 1;
        {m_valid, m_mr, m_mw, m_rw, m_m2r, m_lk} = '0;
        m_xout = 0; m_wd = 0; m_pc = 0; m_wr = 0;
      end else if (bus.Stall) begin
        if (m_stall != 16'hFFFF) m_stall = m_stall + 1;
      end else begin
        m_valid = bus.in_Valid;   m_mr  = bus.in_MemRead;  m_mw = bus.in_MemWrite;
        m_rw    = bus.in_RegWrite; m_m2r = bus.in_MemToReg; m_lk = bus.in_Link;
        m_xout  = bus.in_XOut;    m_wd  = bus.in_WriteData; m_pc = bus.in_PCInc;
        m_wr    = bus.in_WriteReg;
        if (bus.in_Valid) begin
          if ((bus.in_MemRead && bus.in_MemWrite) ||
              ((bus.in_MemRead || bus.in_MemWrite) && bus.in_XOut[0]))
            m_err = 1;
          if (bus.in_Halt) m_mode = 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_Valid",    16'(bus.out_Valid),    16'(m_valid));
      chk("XOut",         bus.XOut,              m_xout);
      chk("WriteData",    bus.WriteData,         m_wd);
      chk("out_PCInc",    bus.out_PCInc,         m_pc);
      chk("out_WriteReg", 16'(bus.out_WriteReg), 16'(m_wr));
      chk("MemRead",      16'(bus.MemRead),      16'(m_mode == 0 && m_valid && m_mr));
      chk("MemWrite",     16'(bus.MemWrite),     16'(m_mode == 0 && m_valid && m_mw));
      chk("out_RegWrite", 16'(bus.out_RegWrite), 16'(m_mode != 2 && m_valid && m_rw));
      chk("out_MemToReg", 16'(bus.out_MemToReg), 16'(m_mode != 2 && m_valid && m_m2r));
      chk("out_Link",     16'(bus.out_Link),     16'(m_mode != 2 && m_valid && m_lk));
      chk("createdump",   16'(bus.createdump),   16'(m_mode == 1));
      chk("halted",       16'(bus.halted),       16'(m_mode == 2));
      chk("err",          16'(bus.err),          16'(m_err));
`ifdef EX_MEM_STATS_EN
      chk("stall_cnt",    bus.stall_cnt,         m_stall);
      chk("bubble_cnt",   bus.bubble_cnt,        m_bubble);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_in();
    bus.Stall = 0; bus.Flush = 0; bus.in_Valid = 0;
    bus.in_XOut = 0; bus.in_WriteData = 0; bus.in_PCInc = 0;
    bus.in_MemRead = 0; bus.in_MemWrite = 0; bus.in_RegWrite = 0;
    bus.in_MemToReg = 0; bus.in_Link = 0; bus.in_WriteReg = 0; bus.in_Halt = 0;
  endtask

  task automatic rand_in();
    bus.Stall        = ($urandom_range(3) == 0);
    bus.Flush        = ($urandom_range(7) == 0);
    bus.in_Valid     = 1'($urandom_range(1));
    bus.in_XOut      = 16'($urandom);
    bus.in_WriteData = 16'($urandom);
    bus.in_PCInc     = 16'($urandom);
    bus.in_MemRead   = ($urandom_range(2) == 0);
    bus.in_MemWrite  = ($urandom_range(2) == 0);
    bus.in_RegWrite  = 1'($urandom_range(1));
    bus.in_MemToReg  = 1'($urandom_range(1));
    bus.in_Link      = 1'($urandom_range(1));
    bus.in_WriteReg  = 3'($urandom_range(7));
    bus.in_Halt      = ($urandom_range(29) == 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    clr_in();
    rst = 1;
    tick();
    chk_en = 1;

    // Reset with random garbage on the inputs
    rand_in();
    rst = 1;
    tick();
    chk("rst_valid",  16'(bus.out_Valid), 16'h0);
    chk("rst_xout",   bus.XOut,           16'h0);
    chk("rst_halted", 16'(bus.halted),    16'h0);
    chk("rst_err",    16'(bus.err),       16'h0);

    // Basic store
    rst = 0; clr_in();
    bus.in_Valid = 1; bus.in_XOut = 16'h1234; bus.in_WriteData = 16'hBEEF; bus.in_MemWrite = 1;
    tick();
    chk("ld_xout", bus.XOut,             16'h1234);
    chk("ld_wd",   bus.WriteData,        16'hBEEF);
    chk("ld_mw",   16'(bus.MemWrite),    16'h1);
    chk("ld_err",  16'(bus.err),         16'h0);

    // Load then three stalled cycles with changing inputs, then stall+flush
    clr_in();
    bus.in_Valid = 1; bus.in_MemRead = 1; bus.in_XOut = 16'h0040;
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.Stall = 1; bus.in_XOut = 16'($urandom) & 16'hFFFE; bus.in_MemRead = 0; bus.in_MemWrite = 1;
      tick();
      chk("stall_xout", bus.XOut,          16'h0040);
      chk("stall_mr",   16'(bus.MemRead),  16'h1);
    end
    bus.Stall = 1; bus.Flush = 1;
    tick();
    chk("flush_valid", 16'(bus.out_Valid), 16'h0);
    chk("flush_mr",    16'(bus.MemRead),   16'h0);

    // Halt captured under Stall only takes effect on the later unstalled load
    clr_in();
    bus.in_Valid = 1; bus.in_Halt = 1; bus.Stall = 1;
    tick();
    chk("halt_stalled_cd", 16'(bus.createdump), 16'h0);
    bus.Stall = 0;
    tick();
    chk("halt_cd",     16'(bus.createdump), 16'h1);
    chk("halt_cd_hlt", 16'(bus.halted),     16'h0);
    clr_in();
    bus.in_Valid = 1; bus.in_MemWrite = 1; bus.in_XOut = 16'h0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halted_cd", 16'(bus.createdump), 16'h0);
      chk("halted_h",  16'(bus.halted),     16'h1);
      chk("halted_mw", 16'(bus.MemWrite),   16'h0);
    end
    rst = 1;
    tick();
    chk("halt_rst_h", 16'(bus.halted), 16'h0);
    rst = 0;

    // rst while in DUMP
    clr_in();
    bus.in_Valid = 1; bus.in_Halt = 1;
    tick();
    clr_in();
    rst = 1;
    tick();
    chk("dump_rst_cd", 16'(bus.createdump), 16'h0);
    rst = 0;

    // Misaligned load sets a sticky error
    clr_in();
    bus.in_Valid = 1; bus.in_MemRead = 1; bus.in_XOut = 16'h0003;
    tick();
    chk("err_set",  16'(bus.err),  16'h1);
    chk("err_xout", bus.XOut,      16'h0003);
    clr_in();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("err_sticky", 16'(bus.err), 16'h1);
    end
    rst = 1;
    tick();
    chk("err_rst", 16'(bus.err), 16'h0);
    rst = 0;
    bus.in_Valid = 0; bus.in_MemRead = 1; bus.in_XOut = 16'h0003;
    tick();
    chk("err_invalid", 16'(bus.err), 16'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rand_in();
      rst = ($urandom_range(39) == 0);
      tick();
    end

`ifdef EX_MEM_STATS_EN
    clr_in();
    rst = 1;
    tick();
    rst = 0;
    bus.Stall = 1;
    repeat (5) tick();
    bus.Stall = 0; bus.Flush = 1;
    repeat (2) tick();
    chk("stats_stall",  bus.stall_cnt,  16'd5);
    chk("stats_bubble", bus.bubble_cnt, 16'd2);
    bus.Flush = 0; bus.Stall = 1;
    repeat (70000) tick();
    chk("stats_sat", bus.stall_cnt, 16'hFFFF);
`endif

    clr_in();
    tick();
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
